// File: rtl/execute_alu_pipe.sv
// execute_alu_pipe: registered execute-stage ALU with valid/ready on both sides and tag passthrough.
// Optional feature macro EXECUTE_ALU_MUL_EN adds op 12 (MUL) using a multi-cycle shift-add FSM.
module execute_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_illegal
);
  localparam int SH_W = $clog2(WIDTH);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SH_W-1:0]         shamt;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ill;

  logic                    drainable;
  logic                    accept;
  logic                    single_acc;
  logic                    is_mul;
  logic                    fsm_idle;
  logic                    mul_load;
  logic [WIDTH-1:0]        mul_res;
  logic [TAG_W-1:0]        mul_tag;

  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    zero_q, zero_d;
  logic                    illegal_q, illegal_d;

  assign a_s   = in_a;
  assign b_s   = in_b;
  assign shamt = in_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_op)
      4'd0:  alu_res = in_a + in_b;
      4'd1:  alu_res = in_a - in_b;
      4'd2:  alu_res = in_a & in_b;
      4'd3:  alu_res = in_a | in_b;
      4'd4:  alu_res = in_a ^ in_b;
      4'd5:  alu_res = in_a << shamt;
      4'd6:  alu_res = in_a >> shamt;
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd8:  alu_res = a_s >>> shamt;
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      4'd10: alu_res = in_b;
`ifdef EXECUTE_ALU_MUL_EN
      // MUL result comes from the FSM, never from this path.
      4'd12: alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  assign drainable  = !valid_q || out_ready;
  assign in_ready   = !flush && drainable && fsm_idle;
  assign accept     = in_valid && in_ready;
  assign single_acc = accept && !is_mul;

`ifdef EXECUTE_ALU_MUL_EN
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_e;

  mstate_e          state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;

  assign is_mul   = (in_op == 4'd12);
  assign fsm_idle = (state_q == M_IDLE);
  assign mul_load = (state_q == M_DONE) && drainable && !flush;
  assign mul_res  = acc_q;
  assign mul_tag  = mtag_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mtag_d   = mtag_q;
    cnt_d    = cnt_q;
    case (state_q)
      M_IDLE: begin
        if (accept && is_mul) begin
          mcand_d  = in_a;
          mplier_d = in_b;
          acc_d    = '0;
          cnt_d    = '0;
          mtag_d   = in_tag;
          state_d  = M_RUN;
        end
      end
      M_RUN: begin
        // One multiplier bit per cycle; the multiplicand shifts up as the multiplier drains.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SH_W'(WIDTH-1)) state_d = M_DONE;
      end
      M_DONE: begin
        if (mul_load) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
    if (flush) state_d = M_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= M_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    mtag_q   <= mtag_d;
    cnt_q    <= cnt_d;
  end
`else
  assign is_mul   = 1'b0;
  assign fsm_idle = 1'b1;
  assign mul_load = 1'b0;
  assign mul_res  = '0;
  assign mul_tag  = '0;
`endif

  // Result register: drain, then reload from either source, with flush overriding valid.
  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    tag_d     = tag_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (single_acc) begin
      valid_d   = 1'b1;
      result_d  = alu_res;
      tag_d     = in_tag;
      zero_d    = (alu_res == '0);
      illegal_d = alu_ill;
    end else if (mul_load) begin
      valid_d   = 1'b1;
      result_d  = mul_res;
      tag_d     = mul_tag;
      zero_d    = (mul_res == '0);
      illegal_d = 1'b0;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      tag_q     <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_tag     = tag_q;
  assign out_zero    = zero_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_execute_alu_pipe.sv
// tb_execute_alu_pipe: directed vectors for execute_alu_pipe, checked against a behavioural model
// every cycle plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_execute_alu_pipe;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    in_op = 4'd0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics: {illegal, result}.
  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int unsigned sh;
    sh = b % W;
    case (op)
      4'd0:  return {1'b0, a + b};
      4'd1:  return {1'b0, a - b};
      4'd2:  return {1'b0, a & b};
      4'd3:  return {1'b0, a | b};
      4'd4:  return {1'b0, a ^ b};
      4'd5:  return {1'b0, a << sh};
      4'd6:  return {1'b0, a >> sh};
      4'd7:  return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      4'd8:  return {1'b0, $signed(a) >>> sh};
      4'd9:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'd10: return {1'b0, b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Model of the consumer-visible state: result slot plus an optional pending multiply.
  bit            m_valid = 1'b0;
  bit            m_busy = 1'b0;
  int            m_wait = 0;
  logic [W-1:0]  m_res = '0;
  logic [TW-1:0] m_tag = '0;
  bit            m_ill = 1'b0;
  logic [W-1:0]  m_pres = '0;
  logic [TW-1:0] m_ptag = '0;

  always @(posedge clk or negedge rst_n) begin
    bit            nv, nb, ni, rdy;
    int            nw;
    logic [W-1:0]  nr, npr;
    logic [TW-1:0] nt, npt;
    logic [W:0]    r;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_wait  <= 0;
    end else begin
      nv = m_valid; nb = m_busy; nw = m_wait; nr = m_res; nt = m_tag; ni = m_ill;
      npr = m_pres; npt = m_ptag;
      rdy = !flush && (!m_valid || out_ready) && !m_busy;
      if (flush) begin
        nv = 1'b0;
        nb = 1'b0;
      end else begin
        if (m_valid && out_ready) nv = 1'b0;
        if (m_busy) begin
          if (m_wait > 1) nw = m_wait - 1;
          else if (!m_valid || out_ready) begin
            nv = 1'b1; nr = m_pres; nt = m_ptag; ni = 1'b0; nb = 1'b0;
          end
        end else if (in_valid && rdy) begin
`ifdef EXECUTE_ALU_MUL_EN
          if (in_op == 4'd12) begin
            nb = 1'b1; nw = W + 1; npr = in_a * in_b; npt = in_tag;
          end else
`endif
          begin
            r = ref_alu(in_op, in_a, in_b);
            nv = 1'b1; nr = r[W-1:0]; ni = r[W]; nt = in_tag;
          end
        end
      end
      m_valid <= nv; m_busy <= nb; m_wait <= nw; m_res <= nr; m_tag <= nt; m_ill <= ni;
      m_pres <= npr; m_ptag <= npt;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    if (!rst_n) begin
      chk("rst_result", out_result, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_zero", out_zero, 0);
      chk("rst_illegal", out_illegal, 0);
    end else begin
      chk("in_ready", in_ready, !flush && (!m_valid || out_ready) && !m_busy);
      if (m_valid) begin
        chk("out_result", out_result, m_res);
        chk("out_tag", out_tag, m_tag);
        chk("out_zero", out_zero, m_res == 0);
        chk("out_illegal", out_illegal, m_ill);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  logic [3:0] vops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                            4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14};

  initial begin
    repeat (3) tick();
    chk("reset_valid", out_valid, 0);
    chk("reset_result", out_result, 0);
    rst_n = 1'b1;
    tick();

    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5);
    chk("add_wrap_valid", out_valid, 1);
    chk("add_wrap_result", out_result, 32'h0);
    chk("add_wrap_zero", out_zero, 1);
    chk("add_wrap_tag", out_tag, 5'd5);

    issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6);
    chk("slt", out_result, 32'h1);
    issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7);
    chk("sltu", out_result, 32'h0);
    issue(4'd8, 32'h8000_0000, 32'h0000_0024, 5'd8);
    chk("sra", out_result, 32'hF800_0000);
    issue(4'd6, 32'h8000_0000, 32'h0000_0024, 5'd8);
    chk("srl", out_result, 32'h0800_0000);
    issue(4'd1, 32'd5, 32'd7, 5'd1);
    chk("sub_wrap", out_result, 32'hFFFF_FFFE);
    issue(4'd5, 32'h1, 32'd33, 5'd1);
    chk("sll_amt_mask", out_result, 32'h2);
    issue(4'd10, 32'h1234_5678, 32'hABCD_E000, 5'd3);
    chk("passb", out_result, 32'hABCD_E000);
    tick();

    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 5'd9);
    chk("bp_result", out_result, 32'd7);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold", out_result, 32'd7);
      chk("bp_hold_tag", out_tag, 5'd9);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd3; in_a = 32'hF0; in_b = 32'h0F; in_tag = 5'd2;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_reload_valid", out_valid, 1);
    chk("bp_reload_result", out_result, 32'hFF);
    chk("bp_reload_tag", out_tag, 5'd2);
    tick();

    out_ready = 1'b0;
    issue(4'd15, 32'h55, 32'h66, 5'd12);
    chk("illegal_flag", out_illegal, 1);
    chk("illegal_result", out_result, 0);
    chk("illegal_tag", out_tag, 5'd12);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd1; in_b = 32'd1;
    #1;
    chk("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    tick();

`ifndef EXECUTE_ALU_MUL_EN
    issue(4'd12, 32'd7, 32'd6, 5'd4);
    chk("op12_illegal", out_illegal, 1);
    chk("op12_result", out_result, 0);
    tick();
`endif

    for (int i = 0; i < 28; i++) begin
      out_ready = (i % 3) != 2;
      in_valid = (i % 5) != 4;
      in_op = vops[i % 14];
      in_a = 32'h9E37_79B9 * i;
      in_b = 32'hDEAD_BEEF ^ (i * 37);
      in_tag = TW'(i);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

`ifdef EXECUTE_ALU_MUL_EN
    issue(4'd12, 32'd7, 32'd6, 5'd11);
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy_ready", in_ready, 0);
      chk("mul_busy_valid", out_valid, 0);
      tick();
    end
    chk("mul_pre_valid", out_valid, 0);
    tick();
    chk("mul_valid", out_valid, 1);
    chk("mul_result", out_result, 32'd42);
    chk("mul_tag", out_tag, 5'd11);
    tick();
    issue(4'd12, 32'd7, 32'd6, 5'd10);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("mul_flushed", out_valid, 0);
      tick();
    end
`endif

    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd1, 5'd3);
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_result", out_result, 0);
    chk("async_rst_tag", out_tag, 0);
    chk("async_rst_zero", out_zero, 0);
    chk("async_rst_illegal", out_illegal, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
